// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use bubble insertion, EX flush and global hold; 1-cycle latency.
// Optional saturating bubble/flush counters when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage_register #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold_i,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    input  logic [XLEN-1:0]       id_pc_i,
    input  logic [XLEN-1:0]       id_rs1_data_i,
    input  logic [XLEN-1:0]       id_rs2_data_i,
    input  logic [XLEN-1:0]       id_imm_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic [2:0]            id_funct3_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  id_write_i,
    input  logic                  id_store_i,
    input  logic                  id_load_i,
    input  logic                  id_branch_i,
    input  logic [1:0]            id_alu_operand_a_selector_i,
    input  logic                  id_alu_operand_b_selector_i,
    input  logic [1:0]            id_next_pc_selector_i,
    input  logic [2:0]            id_alu_operations_selector_i,
    output logic                  ex_valid_o,
    output logic [XLEN-1:0]       ex_pc_o,
    output logic [XLEN-1:0]       ex_rs1_data_o,
    output logic [XLEN-1:0]       ex_rs2_data_o,
    output logic [XLEN-1:0]       ex_imm_o,
    output logic [REG_ADDR_W-1:0] ex_rs1_o,
    output logic [REG_ADDR_W-1:0] ex_rs2_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic [2:0]            ex_funct3_o,
    output logic                  ex_write_o,
    output logic                  ex_store_o,
    output logic                  ex_load_o,
    output logic                  ex_branch_o,
    output logic [1:0]            ex_alu_operand_a_selector_o,
    output logic                  ex_alu_operand_b_selector_o,
    output logic [1:0]            ex_next_pc_selector_o,
    output logic [2:0]            ex_alu_operations_selector_o,
    output logic                  stall_id_o
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]           perf_bubble_cnt_o,
    output logic [31:0]           perf_flush_cnt_o
`endif
);

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic                  write;
        logic                  store;
        logic                  load;
        logic                  branch;
        logic [1:0]            alu_a_sel;
        logic                  alu_b_sel;
        logic [1:0]            next_pc_sel;
        logic [2:0]            alu_op;
    } stage_t;

    stage_t r_ex;
    stage_t w_id;
    logic   w_hazard;
    logic   w_load;

    assign w_id = '{
        valid:       id_valid_i,
        pc:          id_pc_i,
        rs1_data:    id_rs1_data_i,
        rs2_data:    id_rs2_data_i,
        imm:         id_imm_i,
        rs1:         id_rs1_i,
        rs2:         id_rs2_i,
        rd:          id_rd_i,
        funct3:      id_funct3_i,
        write:       id_write_i,
        store:       id_store_i,
        load:        id_load_i,
        branch:      id_branch_i,
        alu_a_sel:   id_alu_operand_a_selector_i,
        alu_b_sel:   id_alu_operand_b_selector_i,
        next_pc_sel: id_next_pc_selector_i,
        alu_op:      id_alu_operations_selector_i
    };

    // A load in EX whose rd is read by the valid ID instruction cannot be forwarded in time.
    assign w_hazard = r_ex.valid & r_ex.load & (r_ex.rd != '0) & id_valid_i &
                      ((id_rs1_used_i & (id_rs1_i == r_ex.rd)) |
                       (id_rs2_used_i & (id_rs2_i == r_ex.rd)));

    assign stall_id_o = w_hazard & ~flush_i;
    assign w_load     = ~flush_i & ~w_hazard & id_valid_i;

    // Flush, hazard and invalid ID all collapse into a fully zeroed bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else if (!hold_i) begin
            r_ex <= w_load ? w_id : '0;
        end
    end

    assign ex_valid_o                   = r_ex.valid;
    assign ex_pc_o                      = r_ex.pc;
    assign ex_rs1_data_o                = r_ex.rs1_data;
    assign ex_rs2_data_o                = r_ex.rs2_data;
    assign ex_imm_o                     = r_ex.imm;
    assign ex_rs1_o                     = r_ex.rs1;
    assign ex_rs2_o                     = r_ex.rs2;
    assign ex_rd_o                      = r_ex.rd;
    assign ex_funct3_o                  = r_ex.funct3;
    assign ex_write_o                   = r_ex.write;
    assign ex_store_o                   = r_ex.store;
    assign ex_load_o                    = r_ex.load;
    assign ex_branch_o                  = r_ex.branch;
    assign ex_alu_operand_a_selector_o  = r_ex.alu_a_sel;
    assign ex_alu_operand_b_selector_o  = r_ex.alu_b_sel;
    assign ex_next_pc_selector_o        = r_ex.next_pc_sel;
    assign ex_alu_operations_selector_o = r_ex.alu_op;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    // Flush takes precedence, so a hazard masked by a flush counts only as a flush bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (!hold_i) begin
            if (flush_i && r_flush_cnt != 32'hFFFF_FFFF)
                r_flush_cnt <= r_flush_cnt + 32'd1;
            if (!flush_i && w_hazard && r_bubble_cnt != 32'hFFFF_FFFF)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign perf_bubble_cnt_o = r_bubble_cnt;
    assign perf_flush_cnt_o  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Bench for id_ex_stage_register: directed pipeline scenarios plus a randomized stream,
// checked every cycle against an instruction-level model of the ID/EX stage.
module tb_id_ex_stage_register;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        wr;
        logic        st;
        logic        ld;
        logic        br;
        logic [1:0]  asel;
        logic        bsel;
        logic [1:0]  npc;
        logic [2:0]  aop;
    } ex_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold = 1'b0;
    logic flush = 1'b0;
    logic u1 = 1'b0;
    logic u2 = 1'b0;
    ex_t  in = '0;
    ex_t  m;
    ex_t  dut_vec;
    logic stall;

    int checks = 0;
    int errors = 0;

    logic        o_valid, o_wr, o_st, o_ld, o_br, o_bsel;
    logic [31:0] o_pc, o_rs1d, o_rs2d, o_imm;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [2:0]  o_f3, o_aop;
    logic [1:0]  o_asel, o_npc;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] o_bcnt, o_fcnt;
    logic [31:0] m_bcnt, m_fcnt;
`endif

    always #5 clk = ~clk;

    id_ex_stage_register #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .hold_i(hold), .flush_i(flush),
        .id_valid_i(in.valid), .id_pc_i(in.pc), .id_rs1_data_i(in.rs1d), .id_rs2_data_i(in.rs2d),
        .id_imm_i(in.imm), .id_rs1_i(in.rs1), .id_rs2_i(in.rs2), .id_rd_i(in.rd),
        .id_funct3_i(in.f3), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
        .id_write_i(in.wr), .id_store_i(in.st), .id_load_i(in.ld), .id_branch_i(in.br),
        .id_alu_operand_a_selector_i(in.asel), .id_alu_operand_b_selector_i(in.bsel),
        .id_next_pc_selector_i(in.npc), .id_alu_operations_selector_i(in.aop),
        .ex_valid_o(o_valid), .ex_pc_o(o_pc), .ex_rs1_data_o(o_rs1d), .ex_rs2_data_o(o_rs2d),
        .ex_imm_o(o_imm), .ex_rs1_o(o_rs1), .ex_rs2_o(o_rs2), .ex_rd_o(o_rd),
        .ex_funct3_o(o_f3), .ex_write_o(o_wr), .ex_store_o(o_st), .ex_load_o(o_ld),
        .ex_branch_o(o_br), .ex_alu_operand_a_selector_o(o_asel),
        .ex_alu_operand_b_selector_o(o_bsel), .ex_next_pc_selector_o(o_npc),
        .ex_alu_operations_selector_o(o_aop), .stall_id_o(stall)
`ifdef ID_EX_PERF_CNT_EN
        , .perf_bubble_cnt_o(o_bcnt), .perf_flush_cnt_o(o_fcnt)
`endif
    );

    assign dut_vec = '{valid: o_valid, pc: o_pc, rs1d: o_rs1d, rs2d: o_rs2d, imm: o_imm,
                       rs1: o_rs1, rs2: o_rs2, rd: o_rd, f3: o_f3, wr: o_wr, st: o_st,
                       ld: o_ld, br: o_br, asel: o_asel, bsel: o_bsel, npc: o_npc, aop: o_aop};

    // Instruction-level view: does the ID instruction need a value the EX load has not produced yet?
    function automatic logic load_use();
        logic reads;
        reads = (u1 && in.rs1 == m.rd) || (u2 && in.rs2 == m.rd);
        return m.valid && m.ld && m.rd != 5'd0 && in.valid && reads;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '0;
`ifdef ID_EX_PERF_CNT_EN
            m_bcnt <= 0;
            m_fcnt <= 0;
`endif
        end else if (!hold) begin
            if (flush || load_use() || !in.valid) m <= '0;
            else                                  m <= in;
`ifdef ID_EX_PERF_CNT_EN
            if (flush && m_fcnt != 32'hFFFF_FFFF) m_fcnt <= m_fcnt + 1;
            if (!flush && load_use() && m_bcnt != 32'hFFFF_FFFF) m_bcnt <= m_bcnt + 1;
`endif
        end
    end

    always @(negedge clk) begin
        checks++;
        if (dut_vec !== m) begin
            errors++;
            $display("FAIL ex_regs actual=%h required=%h", dut_vec, m);
        end
        checks++;
        if (stall !== (load_use() && !flush)) begin
            errors++;
            $display("FAIL stall_model actual=%b required=%b", stall, load_use() && !flush);
        end
`ifdef ID_EX_PERF_CNT_EN
        checks++;
        if (o_bcnt !== m_bcnt || o_fcnt !== m_fcnt) begin
            errors++;
            $display("FAIL perf_cnt actual=%0d/%0d required=%0d/%0d", o_bcnt, o_fcnt, m_bcnt, m_fcnt);
        end
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ex_t instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input logic wr, input logic ld);
        ex_t t;
        t = '0;
        t.valid = 1'b1; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.wr = wr; t.ld = ld;
        t.rs1d = pc ^ 32'hA5A5_0001; t.rs2d = pc ^ 32'h5A5A_0002; t.imm = pc + 32'd4;
        t.f3 = ld ? 3'b010 : 3'b000;
        return t;
    endfunction

    initial begin
        logic [31:0] bc0, fc0;
        bc0 = 0;
        fc0 = 0;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;

        // T2 pass-through: add x3,x1,x2
        in = instr(32'h10, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        u1 = 1'b1; u2 = 1'b1;
        tick();
        chk("t2_pc", o_pc, 32'h10);
        chk("t2_rd", {27'd0, o_rd}, 32'd3);
        chk("t2_write", {31'd0, o_wr}, 32'd1);
        chk("t2_valid", {31'd0, o_valid}, 32'd1);

        // T3 load-use: lw x5 then add x6,x5,x1
        in = instr(32'h14, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1);
        u1 = 1'b1; u2 = 1'b0;
        tick();
        chk("t3_ex_load", {31'd0, o_ld}, 32'd1);
        in = instr(32'h18, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
        u1 = 1'b1; u2 = 1'b1;
        #1;
        chk("t3_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("t3_bubble_valid", {31'd0, o_valid}, 32'd0);
        chk("t3_bubble_write", {31'd0, o_wr}, 32'd0);
        chk("t3_stall_clear", {31'd0, stall}, 32'd0);
        tick();
        chk("t3_add_pc", o_pc, 32'h18);
        chk("t3_add_valid", {31'd0, o_valid}, 32'd1);

        // T4 no false hazard: lw x0 then reader of x0; lw x5 then lui x5
        in = instr(32'h1C, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
        u1 = 1'b1; u2 = 1'b0;
        tick();
        in = instr(32'h20, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        #1;
        chk("t4_x0_stall", {31'd0, stall}, 32'd0);
        in = instr(32'h24, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
        tick();
        in = instr(32'h28, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0);
        u1 = 1'b0; u2 = 1'b0;
        #1;
        chk("t4_lui_stall", {31'd0, stall}, 32'd0);

        // Invalid ID with control bits set enters EX as an all-zero bubble
        in = instr(32'h2C, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1);
        in.valid = 1'b0; in.br = 1'b1; in.npc = 2'b10;
        tick();
        chk("inv_valid", {31'd0, o_valid}, 32'd0);
        chk("inv_ctrl", {28'd0, o_wr, o_ld, o_br, |o_npc}, 32'd0);
        chk("inv_pc", o_pc, 32'd0);

        // T5 flush and hazard in the same cycle
        in = instr(32'h30, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
        u1 = 1'b1;
        tick();
`ifdef ID_EX_PERF_CNT_EN
        bc0 = o_bcnt;
`endif
        in = instr(32'h34, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        chk("t5_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("t5_bubble", {31'd0, o_valid}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk("t5_bubble_cnt", o_bcnt, bc0);
`endif
        flush = 1'b0;

        // T6 hold with flush asserted, then release with flush
        in = instr(32'h40, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
        tick();
        chk("t6_pre_pc", o_pc, 32'h40);
`ifdef ID_EX_PERF_CNT_EN
        bc0 = o_bcnt;
        fc0 = o_fcnt;
`endif
        in = instr(32'h44, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0);
        hold = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold_pc", o_pc, 32'h40);
            chk("t6_hold_load", {31'd0, o_ld}, 32'd1);
        end
        hold = 1'b0;
        tick();
        chk("t6_release_bubble", {31'd0, o_valid}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk("t6_flush_cnt", o_fcnt, fc0 + 32'd1);
        chk("t6_bubble_cnt", o_bcnt, bc0);
`endif
        flush = 1'b0;

        // Mixed stream with narrow register range so load-use collisions are frequent
        for (int i = 0; i < 400; i++) begin
            in = instr($urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 2) == 0));
            in.valid = ($urandom_range(0, 9) != 0);
            in.st = 1'($urandom); in.br = 1'($urandom); in.asel = 2'($urandom);
            in.bsel = 1'($urandom); in.npc = 2'($urandom); in.aop = 3'($urandom);
            u1 = 1'($urandom); u2 = 1'($urandom);
            hold  = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            tick();
        end
        hold = 1'b0; flush = 1'b0;

        // T1 asynchronous reset in the middle of a cycle
        in = instr(32'h80, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
        tick();
        chk("t1_pre_valid", {31'd0, o_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t1_async_valid", {31'd0, o_valid}, 32'd0);
        chk("t1_async_pc", o_pc, 32'd0);
        chk("t1_async_ctrl", {29'd0, o_wr, o_ld, o_rd != 5'd0}, 32'd0);
        chk("t1_async_stall", {31'd0, stall}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t1_after_pc", o_pc, 32'h80);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
